// File: rtl/route_lookup_unit_pkg.sv
// Shared routing definitions: port encoding, routing mode and the
// dimension-order routing function used to fill lookup tables.
package noc_route_pkg;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_E     = 3;
  localparam int PORT_W     = 4;

  typedef enum logic {
    ROUTE_XY = 1'b0,
    ROUTE_YX = 1'b1
  } route_mode_e;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } lookup_state_e;

  // Output port from own (r, c) towards destination (i, j).
  function automatic int dor_port(input int r, input int c, input int i, input int j,
                                  input route_mode_e mode);
    int port;
    if (i == r && j == c) begin
      port = PORT_LOCAL;
    end else if (mode == ROUTE_XY) begin
      if (j != c) port = (j < c) ? PORT_W : PORT_E;
      else        port = (i < r) ? PORT_N : PORT_S;
    end else begin
      if (i != r) port = (i < r) ? PORT_N : PORT_S;
      else        port = (j < c) ? PORT_W : PORT_E;
    end
    return port;
  endfunction

endpackage

// File: rtl/route_lookup_unit_if.sv
// Lookup request/response handshake bundle between header decode
// (master) and the routing table (slave).
interface route_lookup_unit_if #(
  parameter int ADDR_W = 2,
  parameter int PORT_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_dest;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [PORT_W-1:0] rsp_port;
  logic              rsp_err;

  modport master (
    output req_valid, req_dest, rsp_ready,
    input  req_ready, rsp_valid, rsp_port, rsp_err
  );

  modport slave (
    input  req_valid, req_dest, rsp_ready,
    output req_ready, rsp_valid, rsp_port, rsp_err
  );
endinterface

// File: rtl/route_lookup_unit_entry_calc.sv
// Combinational route for one table entry: own address is {row, col},
// table entries are indexed row-major (row = idx / NUM_COLS).
module route_entry_calc
  import noc_route_pkg::*;
#(
  parameter int NUM_COLS       = 2,
  parameter int ROUTE_WIDTH    = 3,
  parameter int RTR_ADDR_WIDTH = 2
) (
  input  logic [RTR_ADDR_WIDTH-1:0] own_addr,
  input  route_mode_e               mode,
  input  logic [RTR_ADDR_WIDTH-1:0] dest_idx,
  output logic [ROUTE_WIDTH-1:0]    port
);

  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int COL_SPAN = 1 << COL_W;

  int own_row;
  int own_col;
  int dst_row;
  int dst_col;

  always_comb begin
    own_row = int'(own_addr) / COL_SPAN;
    own_col = int'(own_addr) % COL_SPAN;
    dst_row = int'(dest_idx) / NUM_COLS;
    dst_col = int'(dest_idx) % NUM_COLS;
    port    = ROUTE_WIDTH'(dor_port(own_row, own_col, dst_row, dst_col, mode));
  end

endmodule

// File: rtl/route_lookup_unit.sv
// Registered routing-table lookup: fills a dimension-order table after reset
// or rebuild, then serves one lookup per cycle with config-write overrides.
module route_lookup_unit
  import noc_route_pkg::*;
#(
  parameter int NUM_ROWS       = 2,
  parameter int NUM_COLS       = 2,
  parameter int NUM_OUTPUTS    = 5,
  parameter int ROUTE_WIDTH    = $clog2(NUM_OUTPUTS),
  parameter int RTR_ADDR_WIDTH = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [RTR_ADDR_WIDTH-1:0] router_address,
  input  logic                      route_mode,
  input  logic                      rebuild,
  input  logic                      cfg_wr,
  input  logic [RTR_ADDR_WIDTH-1:0] cfg_idx,
  input  logic [ROUTE_WIDTH-1:0]    cfg_port,
  output logic                      init_done,
  route_lookup_unit_if.slave        bus
);

  localparam int                        N        = NUM_ROWS * NUM_COLS;
  localparam logic [RTR_ADDR_WIDTH-1:0] LAST_IDX = RTR_ADDR_WIDTH'(N - 1);

  lookup_state_e               state, state_nxt;
  logic [RTR_ADDR_WIDTH-1:0]   idx, idx_nxt;
  logic [RTR_ADDR_WIDTH-1:0]   own_q, own_cur;
  route_mode_e                 mode_q, mode_cur;
  logic                        fill_start;
  logic [ROUTE_WIDTH-1:0]      fill_port;
  logic [ROUTE_WIDTH-1:0]      tbl [N];
  logic                        dest_ok;
  logic                        cfg_ok;
  logic                        accept;

  // The first fill cycle uses the live inputs and latches them for the rest.
  assign fill_start = (state == ST_INIT) && (idx == '0);
  assign own_cur    = fill_start ? router_address : own_q;
  assign mode_cur   = fill_start ? route_mode_e'(route_mode) : mode_q;
  assign dest_ok    = int'(bus.req_dest) < N;
  assign cfg_ok     = int'(cfg_idx) < N;
  assign accept     = bus.req_valid && bus.req_ready;

  route_entry_calc #(
    .NUM_COLS       (NUM_COLS),
    .ROUTE_WIDTH    (ROUTE_WIDTH),
    .RTR_ADDR_WIDTH (RTR_ADDR_WIDTH)
  ) u_calc (
    .own_addr (own_cur),
    .mode     (mode_cur),
    .dest_idx (idx),
    .port     (fill_port)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      idx    <= '0;
      own_q  <= '0;
      mode_q <= ROUTE_XY;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (fill_start) begin
        own_q  <= router_address;
        mode_q <= route_mode_e'(route_mode);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    init_done     = 1'b0;
    bus.req_ready = 1'b0;
    case (state)
      ST_INIT: begin
        idx_nxt = idx + 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = ST_READY;
          idx_nxt   = '0;
        end
      end
      ST_READY: begin
        init_done     = 1'b1;
        bus.req_ready = !bus.rsp_valid || bus.rsp_ready;
        if (rebuild) begin
          state_nxt = ST_INIT;
          idx_nxt   = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Table storage: fill has priority; config writes only land in READY.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      tbl[idx] <= fill_port;
    end else if (cfg_wr && cfg_ok) begin
      tbl[cfg_idx] <= cfg_port;
    end
  end

  // Response stage: reads the pre-write table, so a same-cycle config write
  // to the looked-up index returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_port  <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (accept) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_port  <= dest_ok ? tbl[bus.req_dest] : '0;
      bus.rsp_err   <= !dest_ok;
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_route_lookup_unit.sv
// Directed bench for route_lookup_unit: 2x2, 4x4 and 3x3 instances sharing
// one clock and reset, each scenario in its own task.
module tb_route_lookup_unit;
  import noc_route_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [1:0] ra2, cfg_idx2;
  logic [3:0] ra4, cfg_idx4, ra3, cfg_idx3;
  logic       mode2, mode4, mode3;
  logic       rebuild2, rebuild4, rebuild3;
  logic       cfg_wr2, cfg_wr4, cfg_wr3;
  logic [2:0] cfg_port2, cfg_port4, cfg_port3;
  logic       init_done2, init_done4, init_done3;

  route_lookup_unit_if #(.ADDR_W(2), .PORT_W(3)) b2 ();
  route_lookup_unit_if #(.ADDR_W(4), .PORT_W(3)) b4 ();
  route_lookup_unit_if #(.ADDR_W(4), .PORT_W(3)) b3 ();

  route_lookup_unit #(.NUM_ROWS(2), .NUM_COLS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .router_address(ra2), .route_mode(mode2),
    .rebuild(rebuild2), .cfg_wr(cfg_wr2), .cfg_idx(cfg_idx2), .cfg_port(cfg_port2),
    .init_done(init_done2), .bus(b2)
  );

  route_lookup_unit #(.NUM_ROWS(4), .NUM_COLS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .router_address(ra4), .route_mode(mode4),
    .rebuild(rebuild4), .cfg_wr(cfg_wr4), .cfg_idx(cfg_idx4), .cfg_port(cfg_port4),
    .init_done(init_done4), .bus(b4)
  );

  route_lookup_unit #(.NUM_ROWS(3), .NUM_COLS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .router_address(ra3), .route_mode(mode3),
    .rebuild(rebuild3), .cfg_wr(cfg_wr3), .cfg_idx(cfg_idx3), .cfg_port(cfg_port3),
    .init_done(init_done3), .bus(b3)
  );

  // Counts rising edges until the selected instance reports init_done (bounded).
  task automatic wait_ready(input int which, output int cnt);
    logic done;
    cnt = 0;
    done = 1'b0;
    while (!done && cnt <= 100) begin
      @(negedge clk);
      cnt++;
      done = (which == 2) ? init_done2 : (which == 4) ? init_done4 : init_done3;
    end
  endtask

  task automatic test_reset;
    int cnt;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({init_done2, b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_port} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs_2x2 got %b want 0000000",
               {init_done2, b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_port});
    end
    checks++;
    if ({init_done3, b3.req_ready, b3.rsp_valid, b3.rsp_err, b3.rsp_port} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs_3x3 got %b want 0000000",
               {init_done3, b3.req_ready, b3.rsp_valid, b3.rsp_err, b3.rsp_port});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(2, cnt);
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL init_cycles_2x2 got %0d want 4", cnt);
    end
    checks++;
    if (b2.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_after_init got %b want 1", b2.req_ready);
    end
  endtask

  task automatic test_xy_2x2;
    logic [2:0] exp [4];
    exp = '{3'd0, 3'd3, 3'd2, 3'd3};
    for (int d = 0; d < 4; d++) begin
      b2.req_valid = 1'b1;
      b2.req_dest  = 2'(d);
      @(negedge clk);
      checks++;
      if (b2.rsp_valid !== 1'b1 || b2.rsp_port !== exp[d] || b2.rsp_err !== 1'b0
          || b2.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL xy2x2_dest%0d got v=%b port=%0d err=%b rdy=%b want v=1 port=%0d err=0 rdy=1",
                 d, b2.rsp_valid, b2.rsp_port, b2.rsp_err, b2.req_ready, exp[d]);
      end
    end
    b2.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL xy2x2_drain got rsp_valid=%b want 0", b2.rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    b2.rsp_ready = 1'b0;
    b2.req_valid = 1'b1;
    b2.req_dest  = 2'd1;
    @(negedge clk);
    b2.req_dest = 2'd0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (b2.req_ready !== 1'b0 || b2.rsp_valid !== 1'b1 || b2.rsp_port !== 3'd3) begin
        errors++;
        $display("FAIL stall_cycle%0d got rdy=%b v=%b port=%0d want rdy=0 v=1 port=3",
                 i, b2.req_ready, b2.rsp_valid, b2.rsp_port);
      end
      @(negedge clk);
    end
    b2.rsp_ready = 1'b1;
    #1;
    checks++;
    if (b2.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready got %b want 1", b2.req_ready);
    end
    @(negedge clk);
    checks++;
    if (b2.rsp_valid !== 1'b1 || b2.rsp_port !== 3'd0) begin
      errors++;
      $display("FAIL stall_second_rsp got v=%b port=%0d want v=1 port=0", b2.rsp_valid, b2.rsp_port);
    end
    b2.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_dup got rsp_valid=%b want 0", b2.rsp_valid);
    end
  endtask

  task automatic test_cfg;
    cfg_wr2   = 1'b1;
    cfg_idx2  = 2'd2;
    cfg_port2 = 3'd4;
    @(negedge clk);
    cfg_wr2      = 1'b0;
    b2.req_valid = 1'b1;
    b2.req_dest  = 2'd2;
    @(negedge clk);
    checks++;
    if (b2.rsp_port !== 3'd4 || b2.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL cfg_write_read got v=%b port=%0d want v=1 port=4", b2.rsp_valid, b2.rsp_port);
    end
    cfg_wr2   = 1'b1;
    cfg_port2 = 3'd1;
    @(negedge clk);
    cfg_wr2 = 1'b0;
    checks++;
    if (b2.rsp_port !== 3'd4) begin
      errors++;
      $display("FAIL cfg_same_cycle_old got port=%0d want 4", b2.rsp_port);
    end
    @(negedge clk);
    checks++;
    if (b2.rsp_port !== 3'd1) begin
      errors++;
      $display("FAIL cfg_next_cycle_new got port=%0d want 1", b2.rsp_port);
    end
    b2.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_4x4;
    int cnt;
    wait_ready(4, cnt);
    checks++;
    if (init_done4 !== 1'b1) begin
      errors++;
      $display("FAIL init_4x4 got init_done=%b after %0d cycles want 1", init_done4, cnt);
    end
    b4.req_valid = 1'b1;
    b4.req_dest  = 4'd12;
    @(negedge clk);
    b4.req_valid = 1'b0;
    checks++;
    if (b4.rsp_valid !== 1'b1 || b4.rsp_port !== 3'd2) begin
      errors++;
      $display("FAIL yx4x4_dest12 got v=%b port=%0d want v=1 port=2", b4.rsp_valid, b4.rsp_port);
    end
    mode4    = 1'b0;
    rebuild4 = 1'b1;
    @(negedge clk);
    rebuild4 = 1'b0;
    checks++;
    if (init_done4 !== 1'b0 || b4.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rebuild4x4_enter got done=%b rdy=%b want 0 0", init_done4, b4.req_ready);
    end
    wait_ready(4, cnt);
    checks++;
    if (cnt != 16) begin
      errors++;
      $display("FAIL rebuild4x4_cycles got %0d want 16", cnt);
    end
    b4.req_valid = 1'b1;
    b4.req_dest  = 4'd12;
    @(negedge clk);
    b4.req_valid = 1'b0;
    checks++;
    if (b4.rsp_valid !== 1'b1 || b4.rsp_port !== 3'd4) begin
      errors++;
      $display("FAIL xy4x4_dest12 got v=%b port=%0d want v=1 port=4", b4.rsp_valid, b4.rsp_port);
    end
  endtask

  task automatic test_err_3x3;
    int         cnt;
    logic [3:0] dst [4];
    logic [2:0] prt [4];
    logic       err [4];
    dst = '{4'd12, 4'd3, 4'd8, 4'd4};
    prt = '{3'd0, 3'd4, 3'd3, 3'd0};
    err = '{1'b1, 1'b0, 1'b0, 1'b0};
    wait_ready(3, cnt);
    checks++;
    if (init_done3 !== 1'b1) begin
      errors++;
      $display("FAIL init_3x3 got init_done=%b after %0d cycles want 1", init_done3, cnt);
    end
    for (int k = 0; k < 4; k++) begin
      b3.req_valid = 1'b1;
      b3.req_dest  = dst[k];
      @(negedge clk);
      checks++;
      if (b3.rsp_valid !== 1'b1 || b3.rsp_port !== prt[k] || b3.rsp_err !== err[k]) begin
        errors++;
        $display("FAIL lookup3x3_dest%0d got v=%b port=%0d err=%b want v=1 port=%0d err=%b",
                 dst[k], b3.rsp_valid, b3.rsp_port, b3.rsp_err, prt[k], err[k]);
      end
    end
    b3.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rebuild_pending;
    int   low;
    logic held;
    logic [3:0] dst [3];
    logic [2:0] prt [3];
    dst = '{4'd8, 4'd0, 4'd5};
    prt = '{3'd2, 3'd1, 3'd3};
    b3.rsp_ready = 1'b0;
    b3.req_valid = 1'b1;
    b3.req_dest  = 4'd8;
    @(negedge clk);
    b3.req_valid = 1'b0;
    mode3        = 1'b1;
    rebuild3     = 1'b1;
    @(negedge clk);
    rebuild3 = 1'b0;
    checks++;
    if (b3.rsp_valid !== 1'b1 || b3.rsp_port !== 3'd3 || init_done3 !== 1'b0
        || b3.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rebuild_enter got v=%b port=%0d done=%b rdy=%b want 1 3 0 0",
               b3.rsp_valid, b3.rsp_port, init_done3, b3.req_ready);
    end
    low  = 1;
    held = 1'b1;
    for (int i = 0; i < 20 && !init_done3; i++) begin
      rebuild3  = (i == 2);
      cfg_wr3   = (i == 4);
      cfg_idx3  = 4'd0;
      cfg_port3 = 3'd3;
      if (i == 3) mode3 = 1'b0;
      @(negedge clk);
      if (!(b3.rsp_valid === 1'b1 && b3.rsp_port === 3'd3)) held = 1'b0;
      if (!init_done3) low++;
    end
    rebuild3 = 1'b0;
    cfg_wr3  = 1'b0;
    checks++;
    if (low != 9) begin
      errors++;
      $display("FAIL rebuild_low_cycles got %0d want 9", low);
    end
    checks++;
    if (held !== 1'b1 || b3.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rebuild_rsp_hold got held=%b rdy=%b want held=1 rdy=0", held, b3.req_ready);
    end
    b3.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b3.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rebuild_rsp_drain got v=%b want 0", b3.rsp_valid);
    end
    for (int k = 0; k < 3; k++) begin
      b3.req_valid = 1'b1;
      b3.req_dest  = dst[k];
      @(negedge clk);
      checks++;
      if (b3.rsp_valid !== 1'b1 || b3.rsp_port !== prt[k]) begin
        errors++;
        $display("FAIL yx3x3_dest%0d got v=%b port=%0d want v=1 port=%0d",
                 dst[k], b3.rsp_valid, b3.rsp_port, prt[k]);
      end
    end
    b3.req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_init;
    int cnt;
    b2.rsp_ready = 1'b0;
    b2.req_valid = 1'b1;
    b2.req_dest  = 2'd1;
    @(negedge clk);
    b2.req_valid = 1'b0;
    rebuild2     = 1'b1;
    @(negedge clk);
    rebuild2 = 1'b0;
    @(negedge clk);
    checks++;
    if (b2.rsp_valid !== 1'b1 || b2.rsp_port !== 3'd3 || init_done2 !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset_state got v=%b port=%0d done=%b want 1 3 0",
               b2.rsp_valid, b2.rsp_port, init_done2);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({init_done2, b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_port} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset_2x2 got %b want 0000000",
               {init_done2, b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.rsp_port});
    end
    checks++;
    if (init_done4 !== 1'b0 || b4.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_4x4 got done=%b rdy=%b want 0 0", init_done4, b4.req_ready);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    b2.rsp_ready = 1'b1;
    wait_ready(2, cnt);
    checks++;
    if (cnt != 4) begin
      errors++;
      $display("FAIL refill_cycles got %0d want 4", cnt);
    end
    b2.req_valid = 1'b1;
    b2.req_dest  = 2'd2;
    @(negedge clk);
    checks++;
    if (b2.rsp_valid !== 1'b1 || b2.rsp_port !== 3'd2) begin
      errors++;
      $display("FAIL refill_dest2 got v=%b port=%0d want v=1 port=2", b2.rsp_valid, b2.rsp_port);
    end
    b2.req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ra2 = 2'd0;  mode2 = 1'b0; rebuild2 = 1'b0; cfg_wr2 = 1'b0; cfg_idx2 = '0; cfg_port2 = '0;
    ra4 = 4'd5;  mode4 = 1'b1; rebuild4 = 1'b0; cfg_wr4 = 1'b0; cfg_idx4 = '0; cfg_port4 = '0;
    ra3 = 4'd5;  mode3 = 1'b0; rebuild3 = 1'b0; cfg_wr3 = 1'b0; cfg_idx3 = '0; cfg_port3 = '0;
    b2.req_valid = 1'b0; b2.req_dest = '0; b2.rsp_ready = 1'b1;
    b4.req_valid = 1'b0; b4.req_dest = '0; b4.rsp_ready = 1'b1;
    b3.req_valid = 1'b0; b3.req_dest = '0; b3.rsp_ready = 1'b1;

    test_reset();
    test_xy_2x2();
    test_backpressure();
    test_cfg();
    test_4x4();
    test_err_3x3();
    test_rebuild_pending();
    test_reset_mid_init();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
